// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential double-dabble converter.
package bin_to_bcd_seq_pkg;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] ADJ_THRESH = 4'd5;
  localparam logic [BCD_W-1:0] ADJ_OFFSET = 4'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble digit adjust: 0..4 pass, 5..9 add 3, 10..15 clear.
module bcd_digit_adj
  import bin_to_bcd_seq_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] adj
);

  always_comb begin
    adj = '0;
    if (digit < ADJ_THRESH) begin
      adj = digit;
    end else if (digit <= 4'd9) begin
      adj = digit + ADJ_OFFSET;
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: one bit per clock, start/busy/done handshake,
// overflow flag when the value does not fit in DIGITS decimal digits.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [BIN_W-1:0]          bin,
  output logic                      busy,
  output logic                      done,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic                      overflow
);

  localparam int DIG_W  = BCD_W * DIGITS;
  localparam int WORK_W = DIG_W + BIN_W;
  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state;
  state_t             state_nxt;
  logic [WORK_W-1:0]  work;
  logic [WORK_W-1:0]  work_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_acc;

  // Digit field sits above the binary field; only the digits are adjusted.
  assign work_adj[BIN_W-1:0] = work[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit (work[BIN_W + BCD_W*g +: BCD_W]),
      .adj   (work_adj[BIN_W + BCD_W*g +: BCD_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST_CNT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Anything shifted out of the top digit means the value exceeded DIGITS digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      work     <= '0;
      cnt      <= '0;
      ovf_acc  <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            work    <= {{DIG_W{1'b0}}, bin};
            cnt     <= '0;
            ovf_acc <= 1'b0;
          end
        end
        SHIFT: begin
          work    <= {work_adj[WORK_W-2:0], 1'b0};
          ovf_acc <= ovf_acc | work_adj[WORK_W-1];
          cnt     <= cnt + 1'b1;
        end
        DONE: begin
          bcd      <= work[WORK_W-1 -: DIG_W];
          overflow <= ovf_acc;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq across four width/digit configurations.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  start_v;
  logic [15:0] bin_v [4];
  logic [3:0]  busy_v, done_v, ovf_v;
  logic [11:0] bcd0;
  logic [7:0]  bcd1;
  logic [3:0]  bcd2;
  logic [19:0] bcd3;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;

  localparam int BW [4] = '{8, 8, 1, 16};
  localparam int DG [4] = '{3, 2, 1, 5};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_d0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .bin(bin_v[0][7:0]),
    .busy(busy_v[0]), .done(done_v[0]), .bcd(bcd0), .overflow(ovf_v[0]));
  bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_d1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .bin(bin_v[1][7:0]),
    .busy(busy_v[1]), .done(done_v[1]), .bcd(bcd1), .overflow(ovf_v[1]));
  bin_to_bcd_seq #(.BIN_W(1), .DIGITS(1)) u_d2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .bin(bin_v[2][0:0]),
    .busy(busy_v[2]), .done(done_v[2]), .bcd(bcd2), .overflow(ovf_v[2]));
  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u_d3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .bin(bin_v[3]),
    .busy(busy_v[3]), .done(done_v[3]), .bcd(bcd3), .overflow(ovf_v[3]));

  function automatic logic [19:0] get_bcd(input int id);
    case (id)
      0:       return 20'(bcd0);
      1:       return 20'(bcd1);
      2:       return 20'(bcd2);
      default: return bcd3;
    endcase
  endfunction

  // Decimal digits of v modulo 10^d, packed one nibble per digit.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
    logic [63:0] r = '0;
    longint unsigned n = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int d);
    longint unsigned p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return v > p - 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after an edge with the instance idle; returns after the edge following done.
  task automatic convert(input int id, input logic [15:0] value, output logic [19:0] bcd_o,
                         output logic ovf_o, output int lat, output int busy_cyc,
                         output logic busy_at_done, output logic done_after);
    start_v[id] = 1'b1;
    bin_v[id]   = value;
    @(posedge clk); #1;
    start_v[id] = 1'b0;
    bin_v[id]   = 16'hDEAD;
    lat = 0;
    busy_cyc = 0;
    while (!done_v[id] && lat < 64) begin
      if (busy_v[id]) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    bcd_o        = get_bcd(id);
    ovf_o        = ovf_v[id];
    busy_at_done = busy_v[id];
    @(posedge clk); #1;
    done_after = done_v[id];
  endtask

  task automatic conv_check(input int id, input logic [15:0] value);
    logic [19:0] b;
    logic o, bd, da;
    int lat, bc;
    convert(id, value, b, o, lat, bc, bd, da);
    chk($sformatf("d%0d_bcd_%0d", id, value), 64'(b), ref_bcd(64'(value), DG[id]));
    chk($sformatf("d%0d_ovf_%0d", id, value), 64'(o), 64'(ref_ovf(64'(value), DG[id])));
    chk($sformatf("d%0d_lat_%0d", id, value), 64'(lat), 64'(BW[id] + 1));
  endtask

  task automatic count_done(input int id, input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done_v[id]) pulses++;
    end
  endtask

  initial begin
    logic [19:0] b;
    logic o, bd, da;
    int lat, bc, pulses, prev, n;
    logic [15:0] rv;

    rst = 1'b1;
    start_v = '0;
    for (int i = 0; i < 4; i++) bin_v[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_busy_d%0d", i), 64'(busy_v[i]), 64'd0);
      chk($sformatf("rst_done_d%0d", i), 64'(done_v[i]), 64'd0);
      chk($sformatf("rst_bcd_d%0d", i), 64'(get_bcd(i)), 64'd0);
      chk($sformatf("rst_ovf_d%0d", i), 64'(ovf_v[i]), 64'd0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_busy", 64'(busy_v[0]), 64'd0);

    // 255 with detailed handshake timing
    convert(0, 16'd255, b, o, lat, bc, bd, da);
    chk("t255_bcd", 64'(b), 64'h255);
    chk("t255_ovf", 64'(o), 64'd0);
    chk("t255_lat", 64'(lat), 64'd9);
    chk("t255_busy_cycles", 64'(bc), 64'd9);
    chk("t255_busy_at_done", 64'(bd), 64'd0);
    chk("t255_done_width", 64'(da), 64'd0);

    // exhaustive back-to-back with start held high
    start_v[0] = 1'b1;
    bin_v[0] = 16'd0;
    @(posedge clk); #1;
    bin_v[0] = 16'd1;
    prev = 0;
    for (int k = 0; k < 256; k++) begin
      n = 0;
      while (!done_v[0] && n < 40) begin
        @(posedge clk); #1;
        n++;
      end
      chk($sformatf("exh_bcd_%0d", k), 64'(bcd0), ref_bcd(64'(k), 3));
      chk($sformatf("exh_ovf_%0d", k), 64'(ovf_v[0]), 64'd0);
      if (k > 0) chk($sformatf("exh_period_%0d", k), 64'(cyc - prev), 64'd10);
      else chk("exh_first_lat", 64'(n), 64'd9);
      prev = cyc;
      if (k == 255) start_v[0] = 1'b0;
      else begin
        @(posedge clk); #1;
        bin_v[0] = 16'(k + 2);
      end
    end
    @(posedge clk); #1;

    // two-digit instance: boundary and overflow wrap
    conv_check(1, 16'd99);
    conv_check(1, 16'd100);
    conv_check(1, 16'd199);
    conv_check(1, 16'd255);

    // start while busy is ignored
    start_v[0] = 1'b1;
    bin_v[0] = 16'd42;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start_v[0] = 1'b1;
    bin_v[0] = 16'd7;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 3;
    while (!done_v[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ign_lat", 64'(n), 64'd9);
    chk("ign_bcd", 64'(bcd0), 64'h042);
    count_done(0, 25, pulses);
    chk("ign_no_second_done", 64'(pulses), 64'd0);
    chk("ign_idle", 64'(busy_v[0]), 64'd0);

    // reset mid-conversion
    start_v[0] = 1'b1;
    bin_v[0] = 16'd200;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rmid_busy_before", 64'(busy_v[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rmid_busy", 64'(busy_v[0]), 64'd0);
    chk("rmid_done", 64'(done_v[0]), 64'd0);
    chk("rmid_bcd", 64'(bcd0), 64'd0);
    chk("rmid_ovf", 64'(ovf_v[0]), 64'd0);
    count_done(0, 12, pulses);
    chk("rmid_no_done", 64'(pulses), 64'd0);
    conv_check(0, 16'd13);

    // reset and start together: reset wins
    start_v[0] = 1'b1;
    bin_v[0] = 16'd5;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start_v[0] = 1'b0;
    chk("rst_start_busy", 64'(busy_v[0]), 64'd0);

    // single-bit, single-digit instance
    conv_check(2, 16'd1);
    conv_check(2, 16'd0);

    // sixteen-bit, five-digit instance
    conv_check(3, 16'd65535);
    conv_check(3, 16'd0);
    conv_check(3, 16'd10000);

    // randomized values against the arithmetic model
    for (int i = 0; i < 12; i++) begin
      rv = 16'($urandom_range(0, 255));
      conv_check(0, rv);
      rv = 16'($urandom_range(0, 255));
      conv_check(1, rv);
      rv = 16'($urandom);
      conv_check(3, rv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential double-dabble binary-to-BCD converter, parametrised in input width and output digit count.
- Converts one binary value per request using a start/busy/done handshake. It shifts one bit per clock and applies the per-digit add-3 adjustment.
- Sits between the pump-system level/count registers and the 7-segment display driver.
- Flags values that do not fit in the configured number of digits.

Parameters:
- BIN_W, 8, width of the binary input (>=1).
- DIGITS, 3, number of BCD output digits (>=1).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  BIN_W  binary value; captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress (state != IDLE).
- done  output  1  one-cycle pulse when bcd/overflow are updated.
- bcd  output  4*DIGITS  result; digit i is bcd[4i+3:4i], digit 0 is least significant.
- overflow  output  1  high when bin > 10^DIGITS-1 for the last conversion.

Behaviour:
- Reset state:
  - State is IDLE.
  - busy=0, done=0, bcd=0, overflow=0.
  - Working register and bit counter are cleared.
- States: IDLE, SHIFT, DONE.
- IDLE + start=1 at edge E0:
  - Load the working register {DIGITS x 4'h0, bin}.
  - Clear the overflow accumulator and counter.
  - Go to SHIFT.
- IDLE + start=0: stay in IDLE; outputs hold.
- SHIFT, each edge:
  - Adjust every digit: digit>=5 becomes digit+3; otherwise unchanged.
  - Then shift the whole register left by 1.
  - The bit shifted out of the top digit is ORed into the overflow accumulator.
  - Counter increments.
  - After BIN_W shifts (edge E0+BIN_W), go to DONE.
- DONE, edge E0+BIN_W+1:
  - bcd <= digit field and overflow <= accumulator.
  - done <= 1 for exactly one cycle.
  - Go to IDLE.
- Latency and throughput:
  - done is high between edges E0+BIN_W+1 and E0+BIN_W+2.
  - The earliest next accept is edge E0+BIN_W+2, so back-to-back throughput is one conversion per BIN_W+2 cycles.
- busy is 1 from edge E0 until edge E0+BIN_W+1, then returns to 0.
- bcd and overflow hold their last values until the next DONE; they do not change during SHIFT.
- start while busy is ignored; bin changes while busy have no effect.
- On overflow, bcd = bin mod 10^DIGITS. The lower digits remain exact and higher-order digits are discarded.
- Digit adjust on an out-of-range digit (10..15, unreachable in normal operation) yields 0.
- rst mid-conversion:
  - Returns to IDLE on that edge.
  - All outputs return to their reset values; the conversion is abandoned and no done pulse is produced.
- rst and start in the same cycle: rst wins.
- Widths:
  - Working register is 4*DIGITS+BIN_W bits.
  - Counter width is $clog2(BIN_W+1).

Decomposition:
- Shared package contains:
  - The state enum (IDLE/SHIFT/DONE).
  - ADJ_THRESH=5 and ADJ_OFFSET=3.
  - The BCD digit width constant 4.
- One sub-module, bcd_digit_adj: a 4-bit combinational adjust, with 0..4 passthrough, 5..9 +3, and others 0.
- bcd_digit_adj is instantiated DIGITS times via generate.

Test Plan:
- BIN_W=8, DIGITS=3, bin=8'd255, start pulse at E0 -> busy high 9 cycles; done pulse at E0+9; bcd=12'h255; overflow=0.
- BIN_W=8, DIGITS=3, exhaustive bin=0..255 back-to-back (start held high) -> every done gives bcd matching the decimal digits of bin; one result every 10 cycles; overflow=0.
- BIN_W=8, DIGITS=2:
  - bin=99 -> bcd=8'h99, overflow=0.
  - bin=100 -> bcd=8'h00, overflow=1.
  - bin=199 -> bcd=8'h99, overflow=1.
- bin=8'd42 accepted, then start=1 with bin=8'd7 at E0+3 -> ignored; done at E0+9 with bcd=12'h042; no second done until a new start in IDLE.
- Conversion of 8'd200 with rst at E0+4 -> busy, done, bcd and overflow all 0 on the next cycle; a subsequent conversion of 8'd13 gives bcd=12'h013.
- BIN_W=1, DIGITS=1, bin=1 -> done at E0+2, bcd=4'h1; also BIN_W=16, DIGITS=5, bin=65535 -> bcd=20'h65535, overflow=0.
